// File: rtl/game_sequencer.sv
// Reaction-game sequencer: debounced button, lives/score/level bookkeeping and
// the engine handshake (run enable, single-cycle go strobe, flag sampled in JUDGE).
module game_sequencer #(
    parameter int DEB_COUNT   = 50000,
    parameter int SHOW_CYCLES = 8388608,
    parameter int START_LIVES = 3,
    parameter int MAX_LVL     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       flag,
    output logic       go,
    output logic       run,
    output logic [2:0] lvl,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over,
    output logic       champion
);

    localparam int CW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT + 1) : 1;
    localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_COUNT - 1);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [2:0]    LVL_TOP   = 3'(MAX_LVL);
    localparam logic [1:0]    LIVES_INI = 2'(START_LIVES);

    typedef enum logic [2:0] {
        IDLE, PLAY, JUDGE, SHOW_W, SHOW_L, OVER, CHAMP
    } state_t;

    // Handshake: go is a one-cycle strobe raised only in PLAY when a press is
    // taken; the engine must hold flag steady through the following JUDGE cycle.
    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_q, press_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [1:0]      lives_q, lives_d;
    logic [7:0]      score_q, score_d;

    // Debounce: count consecutive samples that disagree with the accepted level.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            acc_d   = sync2_q;
            cnt_d   = '0;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lvl_d   = lvl_q;
        lives_d = lives_q;
        score_d = score_q;
        go      = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            IDLE: begin
                lvl_d = '0;
                if (press_q) begin
                    lives_d = LIVES_INI;
                    score_d = '0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                run = 1'b1;
                if (press_q) begin
                    go      = 1'b1;
                    state_d = JUDGE;
                end
            end
            JUDGE: begin
                if (flag) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (lvl_q == LVL_TOP) begin
                        state_d = CHAMP;
                    end else begin
                        lvl_d   = lvl_q + 3'd1;
                        timer_d = SHOW_LOAD;
                        state_d = SHOW_W;
                    end
                end else begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = OVER;
                    end else begin
                        timer_d = SHOW_LOAD;
                        state_d = SHOW_L;
                    end
                end
            end
            SHOW_W, SHOW_L: begin
                if (timer_q == '0) state_d = PLAY;
                else               timer_d = timer_q - 1'b1;
            end
            OVER, CHAMP: begin
                if (press_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            timer_q <= '0;
            lvl_q   <= '0;
            lives_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            timer_q <= timer_d;
            lvl_q   <= lvl_d;
            lives_q <= lives_d;
            score_q <= score_d;
        end
    end

    assign lvl       = lvl_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign game_over = (state_q == OVER);
    assign champion  = (state_q == CHAMP);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short debounce/show parameters;
// outputs are sampled on the falling edge.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       flag = 1'b0;
    logic       go, run, game_over, champion;
    logic [2:0] lvl;
    logic [1:0] lives;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    int go_cnt = 0;
    logic go_prev = 1'b0;

    game_sequencer #(
        .DEB_COUNT(4), .SHOW_CYCLES(8), .START_LIVES(3), .MAX_LVL(4)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .flag(flag),
        .go(go), .run(run), .lvl(lvl), .lives(lives), .score(score),
        .game_over(game_over), .champion(champion)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // go strobe monitor: count strobes and reject back-to-back highs.
    always @(negedge clk) begin
        if (go) begin
            go_cnt++;
            check("go_consecutive", {31'd0, go_prev}, 32'd0);
        end
        go_prev = go;
    end

    // Hold btn for exactly 4 samples and wait for the go strobe; lat = negedges to go.
    task automatic do_press(input logic fv, output int lat);
        repeat (8) @(negedge clk);
        flag = fv;
        btn  = 1'b1;
        lat  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 4) btn = 1'b0;
            if (go) begin
                lat = i;
                break;
            end
        end
        btn = 1'b0;
    endtask

    // Start (or leave OVER/CHAMP): press and return the latency to the watched change.
    task automatic press_until(input logic want_run, output int lat);
        repeat (8) @(negedge clk);
        btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 4) btn = 1'b0;
            if (want_run ? run : !(game_over || champion)) begin
                lat = i;
                break;
            end
        end
        btn = 1'b0;
    endtask

    // JUDGE cycle, then count run=0 cycles until PLAY; optionally inject a press in SHOW.
    task automatic judge_show(input int inj_at, output int n);
        @(negedge clk);
        check("judge_run", {31'd0, run}, 32'd0);
        check("judge_go", {31'd0, go}, 32'd0);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == inj_at) btn = 1'b1;
            if (k == inj_at + 4) btn = 1'b0;
            if (run) begin
                n = k - 1;
                break;
            end
        end
        btn = 1'b0;
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        repeat (3) @(negedge clk);
        check("rst_run", {31'd0, run}, 0);
        check("rst_go", {31'd0, go}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_lvl", {29'd0, lvl}, 0);
        check("rst_lives", {30'd0, lives}, 0);
        check("rst_score", {24'd0, score}, 0);
        check("rst_over", {31'd0, game_over}, 0);
        check("rst_champ", {31'd0, champion}, 0);

        // 3-cycle glitch must not start a game.
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch_run", {31'd0, run}, 0);
        check("glitch_lives", {30'd0, lives}, 0);

        // Long hold gives exactly one press.
        btn = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_run", {31'd0, run}, 1);
        check("hold_lives", {30'd0, lives}, 3);
        check("hold_score", {24'd0, score}, 0);
        check("hold_lvl", {29'd0, lvl}, 0);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_still_play", {31'd0, run}, 1);
        check("hold_no_go", go_cnt, 0);

        // Hit 1.
        do_press(1'b1, lat);
        check("hit1_go_lat", lat, 6);
        judge_show(0, n);
        check("hit1_show_len", n, 8);
        check("hit1_score", {24'd0, score}, 1);
        check("hit1_lvl", {29'd0, lvl}, 1);
        check("hit1_go_cnt", go_cnt, 1);

        // Hit 2 with a press landing inside SHOW_W: ignored, no extra go.
        do_press(1'b1, lat);
        check("hit2_go_lat", lat, 6);
        judge_show(2, n);
        check("hit2_show_len", n, 8);
        check("hit2_lvl", {29'd0, lvl}, 2);
        repeat (12) @(negedge clk);
        check("show_press_ignored_go", go_cnt, 2);
        check("show_press_ignored_run", {31'd0, run}, 1);

        // Hit 3 then a miss; reset while in SHOW_L with score 3.
        do_press(1'b1, lat);
        judge_show(0, n);
        check("hit3_score", {24'd0, score}, 3);
        do_press(1'b0, lat);
        check("miss_go_lat", lat, 6);
        @(negedge clk);
        @(negedge clk);
        check("miss_lives", {30'd0, lives}, 2);
        check("miss_score", {24'd0, score}, 3);
        check("miss_lvl", {29'd0, lvl}, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_run", {31'd0, run}, 0);
        check("rst2_lvl", {29'd0, lvl}, 0);
        check("rst2_lives", {30'd0, lives}, 0);
        check("rst2_score", {24'd0, score}, 0);
        check("rst2_over_champ", {30'd0, game_over, champion}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst2_idle", {31'd0, run}, 0);

        // Three misses to game over.
        press_until(1'b1, lat);
        check("start2_lat", lat, 7);
        check("start2_lives", {30'd0, lives}, 3);
        do_press(1'b0, lat);
        judge_show(0, n);
        check("missA_show_len", n, 8);
        check("missA_lives", {30'd0, lives}, 2);
        do_press(1'b0, lat);
        judge_show(0, n);
        check("missB_show_len", n, 8);
        check("missB_lives", {30'd0, lives}, 1);
        do_press(1'b0, lat);
        @(negedge clk);
        @(negedge clk);
        check("over_flag", {31'd0, game_over}, 1);
        check("over_lives", {30'd0, lives}, 0);
        check("over_run", {31'd0, run}, 0);
        repeat (10) @(negedge clk);
        check("over_hold", {31'd0, game_over}, 1);
        check("over_score_frozen", {24'd0, score}, 0);
        press_until(1'b0, lat);
        check("over_exit_lat", lat, 7);
        check("over_exit_run", {31'd0, run}, 0);
        check("over_exit_go_cnt", go_cnt, 7);

        // Five hits to champion.
        press_until(1'b1, lat);
        for (int h = 1; h <= 4; h++) begin
            do_press(1'b1, lat);
            judge_show(0, n);
            check("champ_step_show", n, 8);
            check("champ_step_lvl", {29'd0, lvl}, 32'(h));
        end
        do_press(1'b1, lat);
        @(negedge clk);
        @(negedge clk);
        check("champ_flag", {31'd0, champion}, 1);
        check("champ_score", {24'd0, score}, 5);
        check("champ_lvl", {29'd0, lvl}, 4);
        check("champ_run", {31'd0, run}, 0);
        repeat (10) @(negedge clk);
        check("champ_hold", {31'd0, champion}, 1);
        press_until(1'b0, lat);
        check("champ_exit_lat", lat, 7);
        @(negedge clk);
        check("champ_exit_lvl", {29'd0, lvl}, 0);
        check("final_go_cnt", go_cnt, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
